ahb_protocol_monitor: RTL and testbench

AHB_PROTOCOL_MONITOR -- requirements
Module: ahb_protocol_monitor

---
 rtl/ahb_protocol_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_ahb_protocol_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_protocol_monitor.sv
// Passive AHB-Lite protocol monitor: tracks bursts and error responses and
// reports sticky per-check violations, a saturating count and the first violation code.
module ahb_protocol_monitor #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HREADY,
  input  logic              HREADYOUT,
  input  logic              HRESP,
  input  logic              clr,
  output logic [7:0]        viol_flags,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [2:0]        first_code,
  output logic              first_valid,
  output logic              irq
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BURST = 2'd1, ST_ERR1 = 2'd2} state_e;

  localparam logic [2:0]       MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;
  localparam int               WAIT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] burst,
                                                  input logic [2:0] size);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc = ADDR_W'(1) << size;
    if ((burst != 3'd0) && !burst[0]) begin
      mask      = (ADDR_W'(burst_len(burst)) << size) - ADDR_W'(1);
      next_addr = (addr & ~mask) | ((addr + inc) & mask);
    end else begin
      mask      = '0;
      next_addr = addr + inc;
    end
  endfunction

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    misaligned = |(addr & ((ADDR_W'(1) << size) - ADDR_W'(1)));
  endfunction

  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  state_e            state_q, state_d;
  logic [4:0]        beats_q, beats_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;
  logic [2:0]        burst_q, burst_d;
  logic [2:0]        size_q, size_d;
  logic              prev_err_q, prev_err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        viol_flags_q, viol_flags_d;
  logic [CNT_W-1:0]  viol_cnt_q, viol_cnt_d;
  logic [2:0]        first_code_q, first_code_d;
  logic              first_valid_q, first_valid_d;
  logic              irq_q, irq_d;

  logic       acc_s, acc_seq_s, acc_nonseq_s, acc_idle_s;
  logic       err_first_s, err_second_s, in_burst_s, fixed_s, any_viol_s;
  logic [7:0] viol_s;
  logic       unused_ok_s;

  assign unused_ok_s  = HWRITE;
  assign acc_s        = HSEL & HREADY & HTRANS[1];
  assign acc_seq_s    = acc_s & HTRANS[0];
  assign acc_nonseq_s = acc_s & ~HTRANS[0];
  assign acc_idle_s   = HSEL & HREADY & (HTRANS == 2'b00);
  assign err_first_s  = HRESP & ~HREADYOUT;
  assign err_second_s = HRESP & HREADYOUT;
  assign in_burst_s   = (state_q == ST_BURST);
  assign fixed_s      = (burst_q[2:1] != 2'b00);

  always_comb begin
    viol_s    = 8'h00;
    viol_s[0] = acc_s & misaligned(HADDR, HSIZE);
    viol_s[1] = acc_s & (HSIZE > MAX_SIZE);
    viol_s[2] = acc_seq_s & (state_q == ST_IDLE);
    viol_s[3] = acc_seq_s & in_burst_s & (HADDR != exp_addr_q);
    // BUSY is neither accepted nor idle, so it never ends or shortens a burst
    viol_s[4] = (acc_nonseq_s | acc_idle_s) & in_burst_s & fixed_s & (beats_q != 5'd0) & ~prev_err_q;
    viol_s[5] = acc_seq_s & in_burst_s & burst_q[0] &
                (HADDR[ADDR_W-1:10] != base_addr_q[ADDR_W-1:10]);
    viol_s[6] = (err_second_s & (state_q != ST_ERR1)) | ((state_q == ST_ERR1) & ~err_second_s);
    viol_s[7] = ~HREADY & (wait_q == WAIT_LIM);
    any_viol_s = |viol_s;
  end

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    exp_addr_d  = exp_addr_q;
    base_addr_d = base_addr_q;
    burst_d     = burst_q;
    size_d      = size_q;
    prev_err_d  = (state_q == ST_ERR1);

    if (acc_nonseq_s) begin
      burst_d     = HBURST;
      size_d      = HSIZE;
      base_addr_d = HADDR;
      exp_addr_d  = next_addr(HADDR, HBURST, HSIZE);
      beats_d     = (burst_len(HBURST) != 5'd0) ? burst_len(HBURST) - 5'd1 : 5'd0;
    end else if (acc_seq_s && in_burst_s) begin
      exp_addr_d  = next_addr(HADDR, burst_q, size_q);
      beats_d     = (beats_q != 5'd0) ? beats_q - 5'd1 : 5'd0;
    end else begin
      beats_d     = beats_q;
    end

    if (err_first_s) begin
      state_d = ST_ERR1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_nonseq_s && (HBURST != 3'd0)) state_d = ST_BURST;
          else                                   state_d = ST_IDLE;
        end
        ST_BURST: begin
          // A NONSEQ inside a burst ends it and may immediately open the next one
          if (acc_nonseq_s)                                       state_d = (HBURST != 3'd0) ? ST_BURST : ST_IDLE;
          else if (acc_idle_s)                                    state_d = ST_IDLE;
          else if (acc_seq_s && fixed_s && (beats_q == 5'd1))     state_d = ST_IDLE;
          else                                                    state_d = ST_BURST;
        end
        ST_ERR1: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    if (HREADY)                wait_d = '0;
    else if (wait_q != WAIT_SAT) wait_d = wait_q + WAIT_W'(1);
    else                       wait_d = wait_q;

    if (clr) begin
      viol_flags_d  = viol_s;
      viol_cnt_d    = any_viol_s ? CNT_W'(1) : '0;
      first_valid_d = any_viol_s;
      first_code_d  = any_viol_s ? lowest_bit(viol_s) : 3'd0;
    end else begin
      viol_flags_d  = viol_flags_q | viol_s;
      viol_cnt_d    = (any_viol_s && (viol_cnt_q != CNT_MAX)) ? viol_cnt_q + CNT_W'(1) : viol_cnt_q;
      first_valid_d = first_valid_q | any_viol_s;
      first_code_d  = (!first_valid_q && any_viol_s) ? lowest_bit(viol_s) : first_code_q;
    end
    irq_d = |viol_flags_d;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= ST_IDLE;
      beats_q       <= 5'd0;
      exp_addr_q    <= '0;
      base_addr_q   <= '0;
      burst_q       <= 3'd0;
      size_q        <= 3'd0;
      prev_err_q    <= 1'b0;
      wait_q        <= '0;
      viol_flags_q  <= 8'h00;
      viol_cnt_q    <= '0;
      first_code_q  <= 3'd0;
      first_valid_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      beats_q       <= beats_d;
      exp_addr_q    <= exp_addr_d;
      base_addr_q   <= base_addr_d;
      burst_q       <= burst_d;
      size_q        <= size_d;
      prev_err_q    <= prev_err_d;
      wait_q        <= wait_d;
      viol_flags_q  <= viol_flags_d;
      viol_cnt_q    <= viol_cnt_d;
      first_code_q  <= first_code_d;
      first_valid_q <= first_valid_d;
      irq_q         <= irq_d;
    end
  end

  assign viol_flags  = viol_flags_q;
  assign viol_cnt    = viol_cnt_q;
  assign first_code  = first_code_q;
  assign first_valid = first_valid_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_ahb_protocol_monitor.sv
// Scoreboard bench for ahb_protocol_monitor: each driven cycle carries the violation
// bits it must raise; a small output model turns them into expected register values.
module tb_ahb_protocol_monitor;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 16;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              HSEL = 1'b0;
  logic [ADDR_W-1:0] HADDR = '0;
  logic [1:0]        HTRANS = 2'd0;
  logic              HWRITE = 1'b0;
  logic [2:0]        HSIZE = 3'd0;
  logic [2:0]        HBURST = 3'd0;
  logic              HREADY = 1'b1;
  logic              HREADYOUT = 1'b1;
  logic              HRESP = 1'b0;
  logic              clr = 1'b0;
  logic [7:0]        viol_flags;
  logic [CNT_W-1:0]  viol_cnt;
  logic [2:0]        first_code;
  logic              first_valid;
  logic              irq;

  always #5 HCLK = ~HCLK;

  ahb_protocol_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .clr(clr), .viol_flags(viol_flags),
    .viol_cnt(viol_cnt), .first_code(first_code), .first_valid(first_valid), .irq(irq)
  );

  typedef struct {
    string            tag;
    logic [7:0]       flags;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       code;
    logic             valid;
    logic             irq;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0]       m_flags = 8'h00;
  logic [CNT_W-1:0] m_cnt   = '0;
  logic [2:0]       m_code  = 3'd0;
  logic             m_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // One bus cycle: drive inputs after the falling edge, advance the output model, queue expectation
  task automatic cyc(input string tag, input logic rst, input logic sel, input logic [1:0] trans,
                     input logic [31:0] addr, input logic [2:0] size, input logic [2:0] burst,
                     input logic rdy, input logic rdyout, input logic resp, input logic clr_i,
                     input logic [7:0] v);
    @(negedge HCLK);
    HRESET = rst; HSEL = sel; HTRANS = trans; HADDR = addr; HSIZE = size; HBURST = burst;
    HREADY = rdy; HREADYOUT = rdyout; HRESP = resp; clr = clr_i;
    if (rst) begin
      m_flags = 8'h00; m_cnt = '0; m_code = 3'd0; m_valid = 1'b0;
    end else if (clr_i) begin
      m_flags = v;
      m_cnt   = (v != 8'h00) ? CNT_W'(1) : '0;
      m_valid = (v != 8'h00);
      m_code  = (v != 8'h00) ? low_idx(v) : 3'd0;
    end else begin
      m_flags = m_flags | v;
      if ((v != 8'h00) && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
      if (!m_valid && (v != 8'h00)) begin
        m_valid = 1'b1;
        m_code  = low_idx(v);
      end
    end
    sb_q.push_back('{tag, m_flags, m_cnt, m_code, m_valid, (m_flags != 8'h00)});
  endtask

  task automatic xfer(input string tag, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [2:0] size, input logic [2:0] burst, input logic [7:0] v);
    cyc(tag, 1'b0, 1'b1, trans, addr, size, burst, 1'b1, 1'b1, 1'b0, 1'b0, v);
  endtask

  task automatic idle_cyc(input string tag, input logic clr_i);
    cyc(tag, 1'b0, 1'b0, 2'd0, 32'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, clr_i, 8'h00);
  endtask

  // Compare registered outputs just after each rising edge against the oldest expectation
  always @(posedge HCLK) begin
    #1;
    if (sb_q.size() > 0) begin
      cur_e = sb_q.pop_front();
      check_val({cur_e.tag, ".flags"}, 32'(viol_flags),  32'(cur_e.flags));
      check_val({cur_e.tag, ".cnt"},   32'(viol_cnt),    32'(cur_e.cnt));
      check_val({cur_e.tag, ".code"},  32'(first_code),  32'(cur_e.code));
      check_val({cur_e.tag, ".valid"}, 32'(first_valid), 32'(cur_e.valid));
      check_val({cur_e.tag, ".irq"},   32'(irq),         32'(cur_e.irq));
    end
  end

  initial begin
    cyc("reset0", 1'b1, 1'b0, 2'd0, 32'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc("reset1", 1'b1, 1'b1, 2'd2, 32'h1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    idle_cyc("idle0", 1'b0);

    xfer("wrap4_b0", 2'd2, 32'h38, 3'd2, 3'd2, 8'h00);
    xfer("wrap4_b1", 2'd3, 32'h3C, 3'd2, 3'd2, 8'h00);
    xfer("wrap4_b2", 2'd3, 32'h30, 3'd2, 3'd2, 8'h00);
    xfer("wrap4_b3", 2'd3, 32'h34, 3'd2, 3'd2, 8'h00);
    xfer("seq_after_wrap", 2'd3, 32'h38, 3'd2, 3'd2, 8'h04);
    idle_cyc("clr_a", 1'b1);

    xfer("align", 2'd2, 32'h02, 3'd2, 3'd0, 8'h01);
    idle_cyc("align_hold", 1'b0);
    idle_cyc("clr_b", 1'b1);

    xfer("incr4_b0", 2'd2, 32'h3F8, 3'd2, 3'd3, 8'h00);
    xfer("incr4_b1", 2'd3, 32'h3FC, 3'd2, 3'd3, 8'h00);
    xfer("kb_cross", 2'd3, 32'h400, 3'd2, 3'd3, 8'h20);
    xfer("early_ns", 2'd2, 32'h100, 3'd2, 3'd0, 8'h10);
    idle_cyc("clr_c", 1'b1);

    xfer("busy_b0", 2'd2, 32'h100, 3'd2, 3'd3, 8'h00);
    xfer("busy_mid", 2'd1, 32'h104, 3'd2, 3'd3, 8'h00);
    xfer("busy_b1", 2'd3, 32'h104, 3'd2, 3'd3, 8'h00);
    xfer("seq_addr", 2'd3, 32'h10C, 3'd2, 3'd3, 8'h08);
    xfer("busy_last", 2'd3, 32'h110, 3'd2, 3'd3, 8'h00);
    idle_cyc("busy_idle", 1'b0);
    idle_cyc("clr_d", 1'b1);

    cyc("resp_lone", 1'b0, 1'b1, 2'd0, 32'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h40);
    idle_cyc("clr_e", 1'b1);

    xfer("incr8_b0", 2'd2, 32'h0, 3'd2, 3'd5, 8'h00);
    xfer("incr8_b1", 2'd3, 32'h4, 3'd2, 3'd5, 8'h00);
    xfer("incr8_b2", 2'd3, 32'h8, 3'd2, 3'd5, 8'h00);
    cyc("err_c1", 1'b0, 1'b1, 2'd3, 32'hC, 3'd2, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc("err_c2", 1'b0, 1'b1, 2'd0, 32'hC, 3'd2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    xfer("post_err_ns", 2'd2, 32'h40, 3'd2, 3'd0, 8'h00);
    idle_cyc("post_err_idle", 1'b0);

    cyc("bad_err_c1", 1'b0, 1'b1, 2'd2, 32'h0, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cyc("bad_err_c2", 1'b0, 1'b1, 2'd0, 32'h0, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
    idle_cyc("clr_f", 1'b1);

    for (int i = 1; i <= MAX_WAIT + 2; i++) begin
      cyc($sformatf("wait%0d", i), 1'b0, 1'b0, 2'd0, 32'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
          (i == MAX_WAIT + 1) ? 8'h80 : 8'h00);
    end
    idle_cyc("wait_rearm", 1'b0);

    xfer("sat_align", 2'd2, 32'h1, 3'd2, 3'd0, 8'h01);
    xfer("sat_size",  2'd2, 32'h8, 3'd3, 3'd0, 8'h02);
    xfer("sat_both",  2'd2, 32'h9, 3'd3, 3'd0, 8'h03);
    xfer("sat_again", 2'd2, 32'h1, 3'd2, 3'd0, 8'h01);

    cyc("clr_viol", 1'b0, 1'b1, 2'd2, 32'h1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
    cyc("rst_over", 1'b1, 1'b1, 2'd2, 32'h1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01);

    xfer("rb_b0", 2'd2, 32'h0, 3'd2, 3'd3, 8'h00);
    xfer("rb_b1", 2'd3, 32'h4, 3'd2, 3'd3, 8'h00);
    cyc("rb_reset", 1'b1, 1'b0, 2'd0, 32'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    xfer("rb_seq", 2'd3, 32'h8, 3'd2, 3'd3, 8'h04);
    idle_cyc("final_idle", 1'b0);

    @(negedge HCLK);
    @(posedge HCLK);
    #2;
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
